// File: rtl/packet_error_marker.sv
// AXI-Stream packet qualifier: checks beat count and TKEEP integrity, registers each
// beat once, marks bad packets via TUSER on the last beat and truncates overlong ones.
module packet_error_marker #(
  parameter int DW        = 512,
  parameter int MIN_BEATS = 1,
  parameter int MAX_BEATS = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DW-1:0]     AXIS_IN_TDATA,
  input  logic [DW/8-1:0]   AXIS_IN_TKEEP,
  input  logic              AXIS_IN_TUSER,
  input  logic              AXIS_IN_TLAST,
  input  logic              AXIS_IN_TVALID,
  output logic              AXIS_IN_TREADY,
  output logic [DW-1:0]     AXIS_OUT_TDATA,
  output logic [DW/8-1:0]   AXIS_OUT_TKEEP,
  output logic              AXIS_OUT_TUSER,
  output logic              AXIS_OUT_TLAST,
  output logic              AXIS_OUT_TVALID,
  input  logic              AXIS_OUT_TREADY,
  output logic              bad_packet_strb,
  output logic              trunc_strb,
  output logic [31:0]       good_count,
  output logic [31:0]       bad_count
);

  localparam int KW = DW / 8;
  localparam int CW = $clog2(MAX_BEATS + 1);

  localparam logic [0:0] ST_PASS  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [CW-1:0] MIN_N = CW'(MIN_BEATS);
  localparam logic [CW-1:0] MAX_N = CW'(MAX_BEATS);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          sticky_q, sticky_d;

  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;
  logic          user_q, last_q, valid_q, valid_d;
  logic          bad_strb_q, trunc_strb_q;
  logic [31:0]   good_cnt_q, bad_cnt_q;

  logic          accept;
  logic [CW-1:0] beat_n;
  logic          keep_full, keep_contig, err_now;
  logic          load, ld_last, ld_user, trunc_now;

  assign AXIS_IN_TREADY = (state_q == ST_DRAIN) | ~valid_q | AXIS_OUT_TREADY;
  assign accept         = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign beat_n         = beat_cnt_q + CW'(1);

  // A legal final TKEEP is a non-empty run of ones starting at byte 0.
  assign keep_full   = &AXIS_IN_TKEEP;
  assign keep_contig = (AXIS_IN_TKEEP & (AXIS_IN_TKEEP + KW'(1))) == '0;
  assign err_now     = AXIS_IN_TUSER
                     | (~AXIS_IN_TLAST & ~keep_full)
                     | (AXIS_IN_TLAST & ((AXIS_IN_TKEEP == '0) | ~keep_contig))
                     | (AXIS_IN_TLAST & (beat_n < MIN_N));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    sticky_d   = sticky_q;
    load       = 1'b0;
    ld_last    = 1'b0;
    ld_user    = 1'b0;
    trunc_now  = 1'b0;
    case (state_q)
      ST_PASS: begin
        if (accept) begin
          load = 1'b1;
          if (AXIS_IN_TLAST) begin
            ld_last    = 1'b1;
            ld_user    = sticky_q | err_now;
            sticky_d   = 1'b0;
            beat_cnt_d = '0;
          end else if (beat_n == MAX_N) begin
            ld_last    = 1'b1;
            ld_user    = 1'b1;
            trunc_now  = 1'b1;
            sticky_d   = 1'b0;
            beat_cnt_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            sticky_d   = sticky_q | err_now;
            beat_cnt_d = beat_n;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && AXIS_IN_TLAST) state_d = ST_PASS;
      end
      default: state_d = ST_PASS;
    endcase
  end

  assign valid_d = load | (valid_q & ~AXIS_OUT_TREADY);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_PASS;
      beat_cnt_q <= '0;
      sticky_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      sticky_q   <= sticky_d;
      valid_q    <= valid_d;
    end
  end

  // NOTE: the data path is reset as well, because TDATA/TKEEP must read zero out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      keep_q <= '0;
      user_q <= 1'b0;
      last_q <= 1'b0;
    end else if (load) begin
      data_q <= AXIS_IN_TDATA;
      keep_q <= AXIS_IN_TKEEP;
      user_q <= ld_user;
      last_q <= ld_last;
    end
  end

  // Strobes and counters reflect the packet end just loaded into the output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bad_strb_q   <= 1'b0;
      trunc_strb_q <= 1'b0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
    end else begin
      bad_strb_q   <= load & ld_last & ld_user;
      trunc_strb_q <= trunc_now;
      if (load && ld_last && !ld_user && (good_cnt_q != '1)) good_cnt_q <= good_cnt_q + 32'd1;
      if (load && ld_last &&  ld_user && (bad_cnt_q  != '1)) bad_cnt_q  <= bad_cnt_q  + 32'd1;
    end
  end

  assign AXIS_OUT_TDATA  = data_q;
  assign AXIS_OUT_TKEEP  = keep_q;
  assign AXIS_OUT_TUSER  = user_q;
  assign AXIS_OUT_TLAST  = last_q;
  assign AXIS_OUT_TVALID = valid_q;
  assign bad_packet_strb = bad_strb_q;
  assign trunc_strb      = trunc_strb_q;
  assign good_count      = good_cnt_q;
  assign bad_count       = bad_cnt_q;

endmodule

// File: tb/tb_packet_error_marker.sv
// Bench for packet_error_marker: a packet-level reference model predicts every output
// beat and the counters; directed cases pin the model, then random traffic with back-pressure.
module tb_packet_error_marker;

  localparam int DW   = 128;
  localparam int KW   = DW / 8;
  localparam int MINB = 2;
  localparam int MAXB = 4;
  localparam int MAXL = 8;

  logic          clk, resetn;
  logic [DW-1:0] AXIS_IN_TDATA;
  logic [KW-1:0] AXIS_IN_TKEEP;
  logic          AXIS_IN_TUSER, AXIS_IN_TLAST, AXIS_IN_TVALID, AXIS_IN_TREADY;
  logic [DW-1:0] AXIS_OUT_TDATA;
  logic [KW-1:0] AXIS_OUT_TKEEP;
  logic          AXIS_OUT_TUSER, AXIS_OUT_TLAST, AXIS_OUT_TVALID, AXIS_OUT_TREADY;
  logic          bad_packet_strb, trunc_strb;
  logic [31:0]   good_count, bad_count;

  packet_error_marker #(.DW(DW), .MIN_BEATS(MINB), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TKEEP(AXIS_IN_TKEEP),
    .AXIS_IN_TUSER(AXIS_IN_TUSER), .AXIS_IN_TLAST(AXIS_IN_TLAST),
    .AXIS_IN_TVALID(AXIS_IN_TVALID), .AXIS_IN_TREADY(AXIS_IN_TREADY),
    .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TKEEP(AXIS_OUT_TKEEP),
    .AXIS_OUT_TUSER(AXIS_OUT_TUSER), .AXIS_OUT_TLAST(AXIS_OUT_TLAST),
    .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
    .bad_packet_strb(bad_packet_strb), .trunc_strb(trunc_strb),
    .good_count(good_count), .bad_count(bad_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          user;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    exp_good, exp_bad, exp_trunc;
  int    seen_bad_strb, seen_trunc_strb;
  bit    rand_ready = 0;
  bit    stall_prev = 0;
  beat_t held;

  logic [DW-1:0] pk_data[MAXL];
  logic [KW-1:0] pk_keep[MAXL];
  logic          pk_user[MAXL];
  int            pk_len;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level reference: which beats leave the block, and whether the packet is bad.
  function automatic void model_packet();
    int  olen;
    bit  trunc, is_bad, seen_zero;
    trunc  = pk_len > MAXB;
    olen   = trunc ? MAXB : pk_len;
    is_bad = trunc || (pk_len < MINB);
    for (int i = 0; i < olen; i++) begin
      if (pk_user[i]) is_bad = 1;
      if (i < pk_len - 1) begin
        if (pk_keep[i] != {KW{1'b1}}) is_bad = 1;
      end else begin
        if (pk_keep[i] == '0) is_bad = 1;
        seen_zero = 0;
        for (int b = 0; b < KW; b++) begin
          if (!pk_keep[i][b]) seen_zero = 1;
          else if (seen_zero) is_bad = 1;
        end
      end
    end
    for (int i = 0; i < olen; i++)
      exp_q.push_back('{data: pk_data[i], keep: pk_keep[i],
                        user: (i == olen - 1) && is_bad, last: (i == olen - 1)});
    if (is_bad) exp_bad++; else exp_good++;
    if (trunc) exp_trunc++;
  endfunction

  task automatic set_pkt(input int len);
    pk_len = len;
    for (int i = 0; i < MAXL; i++) begin
      pk_data[i] = {$urandom, $urandom, $urandom, $urandom};
      pk_keep[i] = '1;
      pk_user[i] = 0;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic u, input logic l);
    bit done = 0;
    AXIS_IN_TDATA  = d;
    AXIS_IN_TKEEP  = k;
    AXIS_IN_TUSER  = u;
    AXIS_IN_TLAST  = l;
    AXIS_IN_TVALID = 1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = AXIS_IN_TREADY;
      @(posedge clk);
      #1;
    end
    AXIS_IN_TVALID = 0;
    check("in_ready_timeout", done, 1);
  endtask

  task automatic send_pkt(input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        @(posedge clk);
        #1;
      end
      send_beat(pk_data[i], pk_keep[i], pk_user[i], i == pk_len - 1);
    end
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int t = 0; t < 500 && !idle; t++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !AXIS_OUT_TVALID;
    end
    check("drain_idle", idle, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", AXIS_OUT_TVALID, 0);
    check("rst_out_last",  AXIS_OUT_TLAST,  0);
    check("rst_out_user",  AXIS_OUT_TUSER,  0);
    check("rst_out_data",  AXIS_OUT_TDATA,  0);
    check("rst_out_keep",  AXIS_OUT_TKEEP,  0);
    check("rst_strobes",   {bad_packet_strb, trunc_strb}, 0);
    check("rst_counts",    {good_count, bad_count}, 0);
    check("rst_in_ready",  AXIS_IN_TREADY,  1);
  endtask

  task automatic do_reset();
    resetn = 0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    exp_good = 0; exp_bad = 0; exp_trunc = 0;
    seen_bad_strb = 0; seen_trunc_strb = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    AXIS_IN_TVALID = 0;
  endtask

  initial begin
    AXIS_OUT_TREADY = 1;
    forever begin
      @(posedge clk);
      #1;
      AXIS_OUT_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Single compare process: output beats against the model, hold-under-stall, TUSER rule.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall_prev = 0;
      end else begin
        seen_bad_strb   += int'(bad_packet_strb);
        seen_trunc_strb += int'(trunc_strb);
        if (stall_prev) begin
          check("hold_data", AXIS_OUT_TDATA, held.data);
          check("hold_ctrl", {AXIS_OUT_TKEEP, AXIS_OUT_TUSER, AXIS_OUT_TLAST, AXIS_OUT_TVALID},
                             {held.keep, held.user, held.last, 1'b1});
        end
        if (AXIS_OUT_TVALID) check("user_only_on_last", AXIS_OUT_TUSER & ~AXIS_OUT_TLAST, 0);
        if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", AXIS_OUT_TDATA, e.data);
            check("out_keep", AXIS_OUT_TKEEP, e.keep);
            check("out_last", AXIS_OUT_TLAST, e.last);
            check("out_user", AXIS_OUT_TUSER, e.user);
          end
        end
        stall_prev = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
        held = '{data: AXIS_OUT_TDATA, keep: AXIS_OUT_TKEEP,
                 user: AXIS_OUT_TUSER, last: AXIS_OUT_TLAST};
      end
    end
  end

  initial begin
    int npk;
    AXIS_IN_TDATA = '0; AXIS_IN_TKEEP = '0; AXIS_IN_TUSER = 0;
    AXIS_IN_TLAST = 0;  AXIS_IN_TVALID = 0;
    resetn = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // 3-beat good packet
    set_pkt(3); model_packet(); send_pkt(3, 0); wait_idle();
    check("t1_counts", {good_count, bad_count}, {32'd1, 32'd0});
    check("t1_strobes", seen_bad_strb + seen_trunc_strb, 0);

    // 1-beat packet shorter than MIN_BEATS
    set_pkt(1); model_packet();
    check("model_short_user", exp_q[0].user, 1);
    send_pkt(1, 0); wait_idle();
    check("t2_bad_count", bad_count, 1);
    check("t2_bad_strb", seen_bad_strb, 1);

    // 6-beat packet truncated at 4, then a good 2-beat packet
    set_pkt(6); model_packet();
    check("model_trunc_len", exp_q.size(), 4);
    check("model_trunc_last", {exp_q[3].last, exp_q[3].user, exp_q[2].last}, 3'b110);
    send_pkt(6, 0);
    set_pkt(2); model_packet(); send_pkt(2, 0); wait_idle();
    check("t3_trunc_strb", seen_trunc_strb, 1);
    check("t3_counts", {good_count, bad_count}, {32'd2, 32'd2});

    // upstream error on beat 1 only; bad and good partial-keep last beats
    set_pkt(3); pk_user[0] = 1; model_packet();
    check("model_user_beat3", {exp_q[0].user, exp_q[1].user, exp_q[2].user}, 3'b001);
    send_pkt(3, 0);
    set_pkt(2); pk_keep[1] = 16'h00F0; model_packet(); send_pkt(2, 0);
    set_pkt(2); pk_keep[1] = 16'h00FF; model_packet(); send_pkt(2, 0);
    wait_idle();
    check("t4_counts", {good_count, bad_count}, {32'd3, 32'd4});
    check("t4_strobes", {seen_bad_strb[15:0], seen_trunc_strb[15:0]}, {16'd4, 16'd1});

    // random mixed traffic with 50% output back-pressure
    do_reset();
    rand_ready = 1;
    npk = 1000;
    for (int p = 0; p < npk; p++) begin
      set_pkt($urandom_range(1, 6));
      for (int i = 0; i < pk_len; i++) begin
        pk_user[i] = ($urandom_range(0, 19) == 0);
        if (i < pk_len - 1) begin
          if ($urandom_range(0, 9) == 0) pk_keep[i] = 16'($urandom);
        end else begin
          case ($urandom_range(0, 2))
            0: pk_keep[i] = '1;
            1: pk_keep[i] = {KW{1'b1}} >> (KW - $urandom_range(0, KW));
            default: pk_keep[i] = 16'($urandom);
          endcase
        end
      end
      model_packet();
      send_pkt(pk_len, 1);
    end
    wait_idle();
    check("rand_good_count", good_count, exp_good);
    check("rand_bad_count", bad_count, exp_bad);
    check("rand_pkt_total", good_count + bad_count, npk);
    check("rand_trunc_strb", seen_trunc_strb, exp_trunc);
    check("rand_bad_strb", seen_bad_strb, exp_bad);
    rand_ready = 0;

    // reset asserted while beat 2 of a packet is presented
    set_pkt(3);
    send_beat(pk_data[0], pk_keep[0], 0, 0);
    AXIS_IN_TDATA = pk_data[1]; AXIS_IN_TKEEP = '1; AXIS_IN_TLAST = 0; AXIS_IN_TVALID = 1;
    #2;
    do_reset();
    set_pkt(2); model_packet(); send_pkt(2, 0); wait_idle();
    check("midrst_counts", {good_count, bad_count}, {32'd1, 32'd0});

    // reset while discarding the tail of a truncated packet
    set_pkt(6); model_packet(); send_pkt(5, 0); wait_idle();
    check("drain_trunc_seen", seen_trunc_strb, 1);
    do_reset();
    set_pkt(2); model_packet(); send_pkt(2, 0); wait_idle();
    check("drainrst_counts", {good_count, bad_count}, {32'd1, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_error_marker.md
# packet_error_marker

Stream-side packet qualifier that sits upstream of the bad-packet filter on the receive path, between the MAC/parser output and the filter's input. It validates each AXI-Stream packet for length and TKEEP integrity, passes data through with one cycle of latency, and marks bad packets by asserting TUSER on the last output beat, which is the only place the filter looks for it. Overlong packets are truncated: the block forces TLAST on beat MAX_BEATS and discards the remainder.

## Interface
- DW, 512, TDATA width in bits (multiple of 8)
- MIN_BEATS, 1, minimum legal packet length in beats (≥1)
- MAX_BEATS, 128, maximum legal packet length in beats (≥MIN_BEATS)

- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- AXIS_IN_TDATA  in  DW  input data
- AXIS_IN_TKEEP  in  DW/8  input byte enables
- AXIS_IN_TUSER  in  1  per-beat upstream error flag (any beat)
- AXIS_IN_TLAST  in  1  end of packet
- AXIS_IN_TVALID  in  1  input valid
- AXIS_IN_TREADY  out  1  input ready
- AXIS_OUT_TDATA  out  DW  output data
- AXIS_OUT_TKEEP  out  DW/8  output byte enables
- AXIS_OUT_TUSER  out  1  bad-packet mark; only ever 1 on a TLAST beat
- AXIS_OUT_TLAST  out  1  end of packet (native or forced)
- AXIS_OUT_TVALID  out  1  output valid
- AXIS_OUT_TREADY  in  1  output ready
- bad_packet_strb  out  1  one-cycle pulse per bad packet
- trunc_strb  out  1  one-cycle pulse per truncated packet
- good_count  out  32  packets emitted with TUSER=0, saturating
- bad_count  out  32  packets emitted with TUSER=1, saturating

## Operation
- Output register `obuf` (data, keep, user, last, valid). Input handshake = TVALID & TREADY ("accept").
- States: PASS, DRAIN. Reset → PASS.
- PASS: AXIS_IN_TREADY = !obuf.valid | AXIS_OUT_TREADY. On accept:
  - beat number n = beat_count+1; width clog2(MAX_BEATS+1).
  - err_now = AXIS_IN_TUSER | (!TLAST & TKEEP≠all-ones) | (TLAST & (TKEEP==0 | TKEEP not of form 2^k−1)) | (TLAST & n<MIN_BEATS).
  - bad = sticky_err | err_now.
  - TLAST=1: load obuf with last=1, user=bad; clear sticky_err and beat_count; stay in PASS.
  - TLAST=0 and n==MAX_BEATS: load obuf with last=1, user=1; pulse trunc_strb; clear sticky/count; go to DRAIN.
  - Otherwise: load obuf with last=0, user=0; sticky_err |= err_now; beat_count=n.
- DRAIN: AXIS_IN_TREADY=1; no obuf load. Accepted beats are discarded. On accepting TLAST → PASS. beat_count stays 0.
- obuf.valid clears when AXIS_OUT_TREADY=1 and no new load.
- bad_packet_strb: pulses in the cycle after an obuf load with last=1, user=1. good_count/bad_count increment in the same cycle. Counts saturate at 0xFFFFFFFF.

## Timing
- Latency: input accept at cycle t → AXIS_OUT_TVALID at t+1. Full throughput (1 beat/cycle) while AXIS_OUT_TREADY=1.
- AXIS_IN_TREADY is combinational from AXIS_OUT_TREADY, obuf.valid, and state.
- AXIS_OUT_* holds stable while TVALID=1 and TREADY=0.
- Reset values: AXIS_OUT_TVALID=0, TLAST=0, TUSER=0, TDATA/TKEEP=0, strobes=0, counts=0, AXIS_IN_TREADY=1 (PASS with empty obuf).
- Boundaries:
  - TLAST on beat MAX_BEATS: normal end, not truncated.
  - Single-beat packet with MIN_BEATS=1: legal.
  - Reset mid-packet: the partial packet is lost, and the next accepted beat is beat 1.
  - Reset in DRAIN: returns to PASS.
  - Entering DRAIN with input TLAST already on beat MAX_BEATS cannot occur, because that case is a normal end.

## Test plan
- MIN=2, MAX=4: send a 3-beat packet, all TKEEP=all-ones, TUSER=0 → 3 output beats with TLAST on beat 3 and TUSER=0; good_count=1; no strobes.
- 1-beat packet with TLAST → output TLAST=1, TUSER=1; bad_packet_strb pulses once; bad_count=1.
- 6-beat packet → 4 output beats, beat 4 with TLAST=1 and TUSER=1; trunc_strb=1 and bad_packet_strb=1; beats 5–6 are consumed and not output; the next 2-beat good packet passes intact.
- 3-beat packet with TUSER=1 on beat 1 only → output beats 1–2 have TUSER=0, beat 3 has TUSER=1. Separately, a last beat with TKEEP=0x...0F0 → TUSER=1. A last beat with TKEEP=0x...00FF → TUSER=0.
- Random AXIS_OUT_TREADY back-pressure (50%) over 1000 mixed packets → output is bit-identical to the reference model, no beat is lost or duplicated, and good_count+bad_count equals the number of packets sent.
- Assert resetn low during beat 2 of a packet → all outputs return to reset values. After release, a 2-beat packet is output as a good packet of 2 beats.
